// File: rtl/ascon_aead_ctrl_pkg.sv
// Shared types and constants for the ASCON-AEAD128 encryptor control FSM.
package ascon_aead_ctrl_pkg;

  localparam int ROUNDS_A_DEFAULT = 12;
  localparam int ROUNDS_B_DEFAULT = 8;

  localparam logic [1:0] XOR_E_NONE     = 2'b00;
  localparam logic [1:0] XOR_E_KEY      = 2'b01;
  localparam logic [1:0] XOR_E_DSEP     = 2'b10;
  localparam logic [1:0] XOR_E_KEY_DSEP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD_WAIT,
    ST_AD_PERM,
    ST_PT_WAIT,
    ST_PT_PERM,
    ST_FINAL,
    ST_DONE
  } ctrl_state_t;

  // Reduced-round permutations run the tail of the 12-entry constant table.
  function automatic logic [3:0] round_index(input int rounds, input logic [3:0] count);
    return 4'(12 - rounds) + count;
  endfunction

endpackage

// File: rtl/ascon_aead_ctrl_if.sv
// Host block stream: padded AD/PT blocks in, ciphertext blocks out.
interface ascon_aead_ctrl_if;
  logic [127:0] block_i;
  logic         block_valid_i;
  logic         block_last_i;
  logic         block_ready_o;
  logic [127:0] cipher_o;
  logic         cipher_valid_o;

  modport master (
    output block_i, block_valid_i, block_last_i,
    input  block_ready_o, cipher_o, cipher_valid_o
  );

  modport slave (
    input  block_i, block_valid_i, block_last_i,
    output block_ready_o, cipher_o, cipher_valid_o
  );
endinterface

// File: rtl/ascon_aead_ctrl_round_counter.sv
// 4-bit round counter; terminal count selects between the p^a and p^b limits.
module ascon_aead_ctrl_round_counter #(
  parameter int LIMIT_A = 11,
  parameter int LIMIT_B = 7
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       clear,
  input  logic       enable,
  input  logic       sel_b,
  output logic [3:0] count,
  output logic       tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i) begin
    if (!resetb_i || clear) begin
      count <= '0;
    end else if (enable && count != 4'(LIMIT_A)) begin
      count <= count + 4'd1;
    end
  end

  assign tc = (count == (sel_b ? 4'(LIMIT_B) : 4'(LIMIT_A)));

endmodule

// File: rtl/ascon_aead_ctrl.sv
// ASCON-AEAD128 encryptor control FSM: sequences init, AD/PT absorption and finalization.
// Optional tag comparator is built when ASCON_TAG_CHECK_EN is defined.
module ascon_aead_ctrl
  import ascon_aead_ctrl_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEFAULT,
  parameter int ROUNDS_B = ROUNDS_B_DEFAULT
) (
  input  logic                 clock_i,
  input  logic                 resetb_i,
  input  logic                 start_i,
  input  logic                 has_ad_i,
  ascon_aead_ctrl_if.slave     blk,
  input  logic [127:0]         state_rate_i,
  output logic                 init_o,
  output logic [3:0]           round_o,
  output logic                 enable_state_o,
  output logic                 enable_xor_b_o,
  output logic                 xor_b_final_o,
  output logic [127:0]         data_xor_b_o,
  output logic [1:0]           enable_xor_e_o,
  output logic                 tag_valid_o,
  output logic                 busy_o
`ifdef ASCON_TAG_CHECK_EN
  ,
  input  logic [127:0]         tag_ref_i,
  input  logic [127:0]         state_tag_i,
  output logic                 tag_ok_o
`endif
);

  ctrl_state_t state;
  logic        has_ad_q;
  logic        last_q;
  logic [3:0]  count;
  logic        tc;
  logic        xfer;
  logic        cnt_clear;
  logic        cnt_enable;
  logic        cnt_sel_b;

  assign xfer         = blk.block_valid_i && blk.block_ready_o;
  assign data_xor_b_o = blk.block_i;
  assign blk.cipher_o = blk.block_i ^ state_rate_i;

  ascon_aead_ctrl_round_counter #(
    .LIMIT_A (ROUNDS_A - 1),
    .LIMIT_B (ROUNDS_B - 1)
  ) u_round_counter (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .sel_b    (cnt_sel_b),
    .count    (count),
    .tc       (tc)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    cnt_sel_b  = 1'b0;
    case (state)
      ST_INIT, ST_FINAL: begin
        cnt_enable = 1'b1;
        cnt_clear  = tc;
      end
      ST_AD_PERM, ST_PT_PERM: begin
        cnt_sel_b  = 1'b1;
        cnt_enable = 1'b1;
        cnt_clear  = tc;
      end
      ST_AD_WAIT, ST_PT_WAIT: cnt_enable = xfer;
      default:                cnt_clear  = 1'b1;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state    <= ST_IDLE;
      has_ad_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          state    <= ST_INIT;
          has_ad_q <= has_ad_i;
        end
        ST_INIT:    if (tc) state <= has_ad_q ? ST_AD_WAIT : ST_PT_WAIT;
        ST_AD_WAIT: if (xfer) begin
          state  <= ST_AD_PERM;
          last_q <= blk.block_last_i;
        end
        ST_PT_WAIT: if (xfer) begin
          state  <= blk.block_last_i ? ST_FINAL : ST_PT_PERM;
          last_q <= blk.block_last_i;
        end
        ST_AD_PERM: if (tc) state <= last_q ? ST_PT_WAIT : ST_AD_WAIT;
        ST_PT_PERM: if (tc) state <= ST_PT_WAIT;
        ST_FINAL:   if (tc) state <= ST_DONE;
        ST_DONE:    state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Controls are forced low while reset is asserted, not only after the reset edge.
  always_comb begin
    init_o             = 1'b0;
    round_o            = '0;
    enable_state_o     = 1'b0;
    enable_xor_b_o     = 1'b0;
    xor_b_final_o      = 1'b0;
    enable_xor_e_o     = XOR_E_NONE;
    tag_valid_o        = 1'b0;
    busy_o             = 1'b0;
    blk.block_ready_o  = 1'b0;
    blk.cipher_valid_o = 1'b0;
    if (resetb_i) begin
      busy_o = (state != ST_IDLE);
      case (state)
        ST_INIT: begin
          enable_state_o = 1'b1;
          init_o         = (count == 4'd0);
          round_o        = round_index(ROUNDS_A, count);
          if (tc) enable_xor_e_o = has_ad_q ? XOR_E_KEY : XOR_E_KEY_DSEP;
        end
        ST_AD_WAIT, ST_PT_WAIT: begin
          blk.block_ready_o = 1'b1;
          round_o           = round_index(ROUNDS_B, count);
          if (blk.block_valid_i) begin
            enable_state_o = 1'b1;
            enable_xor_b_o = 1'b1;
            if (state == ST_PT_WAIT) begin
              blk.cipher_valid_o = 1'b1;
              // The last PT absorb doubles as round 0 of finalization.
              if (blk.block_last_i) begin
                xor_b_final_o = 1'b1;
                round_o       = round_index(ROUNDS_A, count);
              end
            end
          end
        end
        ST_AD_PERM: begin
          enable_state_o = 1'b1;
          round_o        = round_index(ROUNDS_B, count);
          if (tc && last_q) enable_xor_e_o = XOR_E_DSEP;
        end
        ST_PT_PERM: begin
          enable_state_o = 1'b1;
          round_o        = round_index(ROUNDS_B, count);
        end
        ST_FINAL: begin
          enable_state_o = 1'b1;
          round_o        = round_index(ROUNDS_A, count);
          if (tc) enable_xor_e_o = XOR_E_KEY;
        end
        ST_DONE: tag_valid_o = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ASCON_TAG_CHECK_EN
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      tag_ok_o <= 1'b0;
    end else if (state == ST_IDLE && start_i) begin
      tag_ok_o <= 1'b0;
    end else if (state == ST_DONE) begin
      tag_ok_o <= (state_tag_i == tag_ref_i);
    end
  end
`endif

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Self-checking bench: a per-cycle expected trace is built from the message shape, then replayed.
module tb_ascon_aead_ctrl;

  localparam int RA = 12;
  localparam int RB = 8;

  logic         clock_i = 1'b0;
  logic         resetb_i;
  logic         start_i;
  logic         has_ad_i;
  logic [127:0] state_rate_i;
  logic         init_o;
  logic [3:0]   round_o;
  logic         enable_state_o;
  logic         enable_xor_b_o;
  logic         xor_b_final_o;
  logic [127:0] data_xor_b_o;
  logic [1:0]   enable_xor_e_o;
  logic         tag_valid_o;
  logic         busy_o;
  logic [127:0] tag_ref_i;
  logic [127:0] state_tag_i;
  logic         tag_ok_o;

  ascon_aead_ctrl_if bus ();

  ascon_aead_ctrl dut (
    .clock_i        (clock_i),
    .resetb_i       (resetb_i),
    .start_i        (start_i),
    .has_ad_i       (has_ad_i),
    .blk            (bus),
    .state_rate_i   (state_rate_i),
    .init_o         (init_o),
    .round_o        (round_o),
    .enable_state_o (enable_state_o),
    .enable_xor_b_o (enable_xor_b_o),
    .xor_b_final_o  (xor_b_final_o),
    .data_xor_b_o   (data_xor_b_o),
    .enable_xor_e_o (enable_xor_e_o),
    .tag_valid_o    (tag_valid_o),
    .busy_o         (busy_o)
`ifdef ASCON_TAG_CHECK_EN
    ,
    .tag_ref_i      (tag_ref_i),
    .state_tag_i    (state_tag_i),
    .tag_ok_o       (tag_ok_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic         rst, start, had, valid, last;
    logic [127:0] blk, rate, tag_ref, stag, exp_cipher;
    logic         busy, ready, init, es, xb, fin, cv, tv, exp_tag_ok;
    logic [3:0]   round;
    logic [1:0]   xe;
  } cyc_t;

  cyc_t sched[$];
  logic model_tag_ok = 1'b0;
  int   tag_mode = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   obs_tv, obs_tv_idx, obs_cv, obs_dsep;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic cyc_t blank(input logic busy);
    cyc_t c;
    c.rst = 1'b1;
    c.start = busy ? 1'($urandom) : 1'b0;
    c.had = 1'($urandom);
    c.valid = 1'($urandom);
    c.last = 1'($urandom);
    c.blk = rnd128();
    c.rate = rnd128();
    c.tag_ref = rnd128();
    c.stag = rnd128();
    c.exp_cipher = '0;
    c.busy = busy;
    c.ready = 0; c.init = 0; c.es = 0; c.xb = 0; c.fin = 0; c.cv = 0; c.tv = 0;
    c.exp_tag_ok = 0;
    c.round = '0;
    c.xe = 2'b00;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    c.exp_tag_ok = model_tag_ok;
    c.exp_cipher = c.blk ^ c.rate;
    sched.push_back(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(blank(1'b0));
  endtask

  task automatic reset_cycles(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(1'b0);
      c.rst = 1'b0;
      c.start = 1'($urandom);
      push(c);
    end
    model_tag_ok = 1'b0;
  endtask

  // One AD or PT block: optional wait cycles, the transfer, then the remaining p^b rounds.
  task automatic absorb(input logic is_pt, input logic last, input int stalls);
    cyc_t c;
    for (int s = 0; s < stalls; s++) begin
      c = blank(1'b1);
      c.valid = 1'b0; c.ready = 1'b1; c.round = 4'(12 - RB);
      push(c);
    end
    c = blank(1'b1);
    c.valid = 1'b1; c.last = last; c.ready = 1'b1; c.es = 1'b1; c.xb = 1'b1;
    c.round = 4'(12 - RB);
    c.cv = is_pt;
    if (is_pt && last) begin
      c.fin = 1'b1;
      c.round = 4'(12 - RA);
      push(c);
      return;
    end
    push(c);
    for (int r = 1; r < RB; r++) begin
      c = blank(1'b1);
      c.es = 1'b1;
      c.round = 4'(12 - RB + r);
      if (!is_pt && last && r == RB - 1) c.xe = 2'b10;
      push(c);
    end
  endtask

  task automatic build_msg(input logic has_ad, input int n_ad, input int n_pt,
                           input int stall_max, input int pt0_stall);
    cyc_t c;
    c = blank(1'b0);
    c.start = 1'b1; c.had = has_ad;
    push(c);
    model_tag_ok = 1'b0;
    for (int r = 0; r < RA; r++) begin
      c = blank(1'b1);
      c.es = 1'b1; c.init = (r == 0); c.round = 4'(12 - RA + r);
      if (r == RA - 1) c.xe = has_ad ? 2'b01 : 2'b11;
      push(c);
    end
    if (has_ad)
      for (int b = 0; b < n_ad; b++) absorb(1'b0, b == n_ad - 1, $urandom_range(0, stall_max));
    for (int b = 0; b < n_pt; b++)
      absorb(1'b1, b == n_pt - 1,
             (b == 0 && pt0_stall >= 0) ? pt0_stall : int'($urandom_range(0, stall_max)));
    for (int r = 1; r < RA; r++) begin
      c = blank(1'b1);
      c.es = 1'b1; c.round = 4'(12 - RA + r);
      if (r == RA - 1) c.xe = 2'b01;
      push(c);
    end
    c = blank(1'b1);
    c.tv = 1'b1;
    if (tag_mode == 1) c.tag_ref = c.stag;
    else if (tag_mode == 2) c.tag_ref = c.stag ^ (128'd1 << $urandom_range(0, 127));
    push(c);
    model_tag_ok = (c.stag == c.tag_ref);
  endtask

  task automatic run_sched(input string name);
    cyc_t c;
    logic [13:0] act, exp;
    obs_tv = 0; obs_tv_idx = -1; obs_cv = 0; obs_dsep = 0;
    for (int i = 0; i < sched.size(); i++) begin
      c = sched[i];
      @(negedge clock_i);
      resetb_i = c.rst; start_i = c.start; has_ad_i = c.had;
      bus.block_valid_i = c.valid; bus.block_last_i = c.last; bus.block_i = c.blk;
      state_rate_i = c.rate; tag_ref_i = c.tag_ref; state_tag_i = c.stag;
      #1;
      exp = {c.busy, c.ready, c.init, c.es, c.xb, c.fin, c.cv, c.tv, c.round, c.xe};
      act = {busy_o, bus.block_ready_o, init_o, enable_state_o, enable_xor_b_o, xor_b_final_o,
             bus.cipher_valid_o, tag_valid_o, round_o, enable_xor_e_o};
      n_checks++;
      if (act !== exp)
        $display("FAIL %s ctl cycle %0d: {busy,rdy,init,es,xb,fin,cv,tv,round,xe} got %b expected %b",
                 name, i, act, exp);
      else n_pass++;
      n_checks++;
      if ({data_xor_b_o, bus.cipher_o} !== {c.blk, c.exp_cipher})
        $display("FAIL %s data cycle %0d: xor_b/cipher got %h/%h expected %h/%h",
                 name, i, data_xor_b_o, bus.cipher_o, c.blk, c.exp_cipher);
      else n_pass++;
`ifdef ASCON_TAG_CHECK_EN
      n_checks++;
      if (tag_ok_o !== c.exp_tag_ok)
        $display("FAIL %s tag_ok cycle %0d: got %b expected %b", name, i, tag_ok_o, c.exp_tag_ok);
      else n_pass++;
`endif
      if (tag_valid_o === 1'b1) begin
        if (obs_tv_idx < 0) obs_tv_idx = i;
        obs_tv++;
      end
      if (bus.cipher_valid_o === 1'b1) obs_cv++;
      if (enable_xor_e_o === 2'b10) obs_dsep++;
    end
    sched.delete();
  endtask

  task automatic test_reset();
    reset_cycles(3);
    idle(3);
    run_sched("reset");
  endtask

  task automatic test_no_ad_single_pt();
    tag_mode = 0;
    build_msg(1'b0, 0, 1, 0, 0);
    idle(2);
    run_sched("no_ad_1pt");
    n_checks++;
    if (obs_tv_idx + 1 !== 26)
      $display("FAIL latency: tag_valid in cycle %0d expected 26", obs_tv_idx + 1);
    else n_pass++;
    n_checks++;
    if (obs_tv !== 1) $display("FAIL tag_valid_width: got %0d cycles expected 1", obs_tv);
    else n_pass++;
  endtask

  task automatic test_ad_pt();
    tag_mode = 0;
    build_msg(1'b1, 2, 2, 0, 0);
    idle(1);
    run_sched("ad2_pt2");
    n_checks++;
    if (obs_cv !== 2) $display("FAIL cipher_valid_count: got %0d expected 2", obs_cv);
    else n_pass++;
    n_checks++;
    if (obs_dsep !== 1) $display("FAIL dsep_count: got %0d expected 1", obs_dsep);
    else n_pass++;
  endtask

  task automatic test_stall();
    build_msg(1'b0, 0, 2, 0, 5);
    idle(1);
    run_sched("pt_stall5");
  endtask

  task automatic test_cipher();
    logic [127:0] b, r, e;
    b = 128'h0123456789ABCDEF0123456789ABCDEF;
    r = {128{1'b1}};
    e = 128'hFEDCBA9876543210FEDCBA9876543210;
    build_msg(1'b0, 0, 1, 0, 0);
    idle(1);
    for (int i = 0; i < sched.size(); i++) begin
      if (sched[i].cv) begin
        sched[i].blk = b;
        sched[i].rate = r;
        sched[i].exp_cipher = e;
      end
    end
    run_sched("cipher_const");
    n_checks++;
    if (obs_cv !== 1) $display("FAIL cipher_const_valid: got %0d expected 1", obs_cv);
    else n_pass++;
  endtask

  task automatic test_reset_mid_final();
    int k;
    build_msg(1'b0, 0, 1, 0, 0);
    k = -1;
    for (int i = RA + 2; i < sched.size(); i++)
      if (k < 0 && sched[i].es && !sched[i].xb && sched[i].round == 4'(12 - RA + 5)) k = i;
    while (sched.size() > k + 1) void'(sched.pop_back());
    sched[k].rst = 1'b0;
    sched[k].busy = 0; sched[k].es = 0; sched[k].round = '0;
    model_tag_ok = 1'b0;
    idle(4);
    build_msg(1'b1, 1, 1, 2, -1);
    idle(2);
    run_sched("reset_mid_final");
    n_checks++;
    if (obs_tv !== 1) $display("FAIL reset_mid_final_tv: got %0d pulses expected 1", obs_tv);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      tag_mode = $urandom_range(0, 2);
      build_msg(1'($urandom), $urandom_range(1, 3), $urandom_range(1, 3), 3, -1);
      idle($urandom_range(0, 2));
    end
    run_sched("random");
  endtask

  task automatic test_back_to_back();
    tag_mode = 1;
    build_msg(1'b1, 1, 2, 1, -1);
    build_msg(1'b0, 0, 1, 1, -1);
    idle(1);
    run_sched("back_to_back");
    n_checks++;
    if (obs_tv !== 2) $display("FAIL back_to_back_tv: got %0d pulses expected 2", obs_tv);
    else n_pass++;
  endtask

`ifdef ASCON_TAG_CHECK_EN
  task automatic test_tag_check();
    tag_mode = 1;
    build_msg(1'b0, 0, 1, 0, 0);
    idle(3);
    tag_mode = 2;
    build_msg(1'b1, 1, 1, 0, 0);
    idle(2);
    tag_mode = 1;
    build_msg(1'b0, 0, 1, 0, 0);
    run_sched("tag_check");
  endtask
`endif

  initial begin
    resetb_i = 1'b0; start_i = 1'b0; has_ad_i = 1'b0;
    bus.block_valid_i = 1'b0; bus.block_last_i = 1'b0; bus.block_i = '0;
    state_rate_i = '0; tag_ref_i = '0; state_tag_i = '0;
    test_reset();
    test_no_ad_single_pt();
    test_ad_pt();
    test_stall();
    test_cipher();
    test_reset_mid_final();
    test_random();
    test_back_to_back();
`ifdef ASCON_TAG_CHECK_EN
    test_tag_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ascon_aead_ctrl.md
Name: ascon_aead_ctrl

Overview:
- Control FSM that sits directly upstream of the permutation/XOR datapath in the ASCON-AEAD128 encryptor.
- Sequences the 12-round initialization, the 8-round associated-data and plaintext absorption, and the 12-round finalization.
- Drives the datapath's init, round, state-enable and XOR controls, one round per clock.
- Produces ciphertext blocks through a valid/ready block interface and flags tag availability.

Parameters:
- ROUNDS_A, 12, rounds of p^a (init, finalization); round index = 12-ROUNDS_A+count
- ROUNDS_B, 8, rounds of p^b (AD/PT absorption); round index = 12-ROUNDS_B+count

Ports:
- clock_i  in  1  system clock
- resetb_i  in  1  reset, synchronous, active-low
- start_i  in  1  start new message; sampled in IDLE only
- has_ad_i  in  1  message carries associated data; latched on start
- block_i  in  128  padded AD/PT block from host
- block_valid_i  in  1  block_i valid
- block_last_i  in  1  current block is last of its phase
- block_ready_o  out  1  controller accepts block this cycle
- state_rate_i  in  128  rate word (S0||S1) of datapath state_p_o
- init_o  out  1  datapath mux selects fresh initial state
- round_o  out  4  round-constant index
- enable_state_o  out  1  datapath state-register enable
- enable_xor_b_o  out  1  XOR block into rate before round
- xor_b_final_o  out  1  final-absorb mode: rate XOR plus key into capacity
- data_xor_b_o  out  128  equals block_i
- enable_xor_e_o  out  2  end XOR: 00 none, 01 key, 10 domain-separation, 11 key+domain-separation
- cipher_o  out  128  block_i XOR state_rate_i
- cipher_valid_o  out  1  cipher_o valid (PT transfers only)
- tag_valid_o  out  1  one-cycle pulse: datapath state holds final tag
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset:
  - resetb_i low at a rising edge forces IDLE and clears the counter and latches, including mid-operation.
  - All outputs are 0 during reset and in IDLE, except the pass-through data_xor_b_o and cipher_o.
- States: IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL, DONE.
- IDLE:
  - start_i moves to INIT.
  - Latches has_ad_i.
- INIT: ROUNDS_A cycles, enable_state_o=1, counter 0..ROUNDS_A-1.
  - Count 0: init_o=1.
  - Last count: enable_xor_e_o=01 if has_ad, else 11.
  - Exit to AD_WAIT if has_ad, else PT_WAIT.
- AD_WAIT / PT_WAIT:
  - block_ready_o=1 combinationally.
  - No transfer: enable_state_o=0, counter holds (stall of any length).
  - Transfer (valid&&ready) in AD_WAIT:
    - That cycle is round count 0: enable_state_o=1, enable_xor_b_o=1.
    - Next state AD_PERM, counter=1; latch block_last_i.
  - Transfer in PT_WAIT, not last:
    - As above, plus cipher_valid_o=1; next state PT_PERM.
  - Transfer in PT_WAIT, last:
    - Count 0 of finalization: enable_xor_b_o=1, xor_b_final_o=1, cipher_valid_o=1, round index 12-ROUNDS_A.
    - Next state FINAL.
- AD_PERM / PT_PERM:
  - Counts 1..ROUNDS_B-1, enable_state_o=1.
  - At the last count of the last AD block: enable_xor_e_o=10.
  - Exit to the matching WAIT state (AD last goes to PT_WAIT).
- FINAL:
  - Counts 1..ROUNDS_A-1.
  - Last count: enable_xor_e_o=01.
  - Then DONE.
- DONE:
  - tag_valid_o=1 for exactly one cycle; the tag is the low 128 bits of the datapath state.
  - Return to IDLE.
- start_i is ignored when not in IDLE; block_valid_i is ignored outside the WAIT states.
- Counter is 4 bits and is never allowed to exceed ROUNDS_A-1.
- round_o = (12-ROUNDS_x)+count, combinational from state and counter.
- Minimum message time (no AD, 1 PT block): 1+12+12+1 cycles, start to tag_valid.

Optional Feature:
- Macro: ASCON_TAG_CHECK_EN.
- When defined:
  - Adds inputs tag_ref_i[127:0] and state_tag_i[127:0], and output tag_ok_o.
  - In DONE, tag_ok_o = (state_tag_i==tag_ref_i); the result is registered and held until the next start or reset.
  - Reset value of tag_ok_o is 0.
- When undefined: these ports are absent and there is no comparator logic.

Decomposition:
- ascon_pack gains:
  - a ctrl_state_t enum for the eight states;
  - XOR_E_NONE/KEY/DSEP/KEY_DSEP 2-bit localparams;
  - ROUNDS_A/ROUNDS_B defaults.
- Sub-module round_counter holds the 4-bit counter with clear, enable and terminal-count output; terminal count is compared against a parameterised limit.

Test Plan:
- Reset mid-FINAL (resetb_i=0 at count 5):
  - Next edge: IDLE, busy_o=0, enable_state_o=0, tag_valid_o stays 0.
- has_ad=0, one PT block valid immediately:
  - INIT rounds 0..11, with enable_xor_e_o=11 at round 11.
  - Final absorb at round 0 with xor_b_final_o=1.
  - tag_valid_o exactly 26 cycles after start, high 1 cycle.
- has_ad=1, 2 AD + 2 PT blocks, no stalls:
  - AD round_o sequence 4..11 twice; enable_xor_e_o=10 only at the 2nd AD round 11.
  - cipher_valid_o exactly twice.
- Stall of 5 cycles in PT_WAIT:
  - enable_state_o=0 and block_ready_o=1 throughout; round_o frozen; no state advance.
- cipher_o check:
  - block_i=0x0123..EF, state_rate_i=0xFFFF..FF → cipher_o=0xFEDC..10 with cipher_valid_o=1 on transfer.
- ASCON_TAG_CHECK_EN:
  - tag_ref_i equal to state_tag_i at DONE → tag_ok_o=1.
  - One flipped bit → 0.
  - Held until next start.
